// File: rtl/calc_alu_sequencer.sv
// calc_alu_sequencer: sequences the shared sign-magnitude add/sub datapath and keeps a chaining accumulator.
// Optional feature: define CALC_OVF_DETECT_EN to enable overflow detection (o_ovf), else o_ovf is tied 0.
// Ports:
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_start, i_op         request pulse (IDLE only); 00 ADD, 01 SUB, 10 ACC_ADD, 11 ACC_SUB
//   i_a, i_b, i_sign_*    operand magnitudes and signs (1 = negative)
//   i_clr                 clear accumulator (IDLE only, applied before a same-cycle Start)
//   i_ack                 result accepted (DONE only)
//   o_busy, o_done        request in progress / result valid until ack
//   o_result, o_result_sign, o_ovf   sign-magnitude result and overflow flag
//   o_dp_a, o_dp_b, o_dp_sign_*, o_dp_rst   datapath operand drive and hold
//   i_dp_diff             datapath two's-complement difference (A - B)
module calc_alu_sequencer #(
   parameter int W      = 8,
   parameter int DP_LAT = 1
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_start,
   input  logic [1:0]   i_op,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_sign_a,
   input  logic         i_sign_b,
   input  logic         i_clr,
   input  logic         i_ack,
   output logic         o_busy,
   output logic         o_done,
   output logic [W-1:0] o_result,
   output logic         o_result_sign,
   output logic         o_ovf,
   output logic [W-1:0] o_dp_a,
   output logic [W-1:0] o_dp_b,
   output logic         o_dp_sign_a,
   output logic         o_dp_sign_b,
   output logic         o_dp_rst,
   input  logic [W-1:0] i_dp_diff
);
   localparam int CW = (DP_LAT > 0) ? $clog2(DP_LAT + 1) : 1;
   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CONV, S_DONE} state_t;
   state_t r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic [W-1:0]  r_dp_a, r_dp_b, r_diff, r_result, r_acc_mag;
   logic          r_dp_sign_a, r_dp_sign_b, r_result_sign, r_acc_sign;
   logic          w_acc_op, w_acc_sign, w_neg, w_sign;
   logic [W-1:0]  w_acc_mag, w_mag;
   // a Clr coinciding with Start must already be visible to an ACC op
   assign w_acc_op   = i_op[1];
   assign w_acc_mag  = i_clr ? '0 : r_acc_mag;
   assign w_acc_sign = i_clr ? 1'b0 : r_acc_sign;
   assign w_neg      = r_diff[W-1];
   assign w_mag      = w_neg ? W'(-r_diff) : r_diff;
   // negating a nonzero value never yields zero, so the sign is simply the MSB
   assign w_sign     = w_neg;
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = i_start ? S_ISSUE : S_IDLE;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  w_next = (r_cnt == CW'(DP_LAT)) ? S_CONV : S_WAIT;
         S_CONV:  w_next = S_DONE;
         S_DONE:  w_next = i_ack ? S_IDLE : S_DONE;
         default: w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_dp_a        <= '0;
         r_dp_b        <= '0;
         r_dp_sign_a   <= 1'b0;
         r_dp_sign_b   <= 1'b0;
         r_diff        <= '0;
         r_result      <= '0;
         r_result_sign <= 1'b0;
         r_acc_mag     <= '0;
         r_acc_sign    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (r_state == S_WAIT) ? r_cnt + 1'b1 : '0;
         if (r_state == S_IDLE && i_clr) begin
            r_acc_mag  <= '0;
            r_acc_sign <= 1'b0;
         end
         if (r_state == S_IDLE && i_start) begin
            r_dp_a      <= w_acc_op ? w_acc_mag : i_a;
            r_dp_sign_a <= w_acc_op ? w_acc_sign : i_sign_a;
            r_dp_b      <= i_b;
            // the datapath subtracts, so an add flips the sign of B
            r_dp_sign_b <= i_op[0] ? i_sign_b : ~i_sign_b;
         end
         if (r_state == S_WAIT && w_next == S_CONV)
            r_diff <= i_dp_diff;
         if (r_state == S_CONV) begin
            r_result      <= w_mag;
            r_result_sign <= w_sign;
            r_acc_mag     <= w_mag;
            r_acc_sign    <= w_sign;
         end
      end
   end
`ifdef CALC_OVF_DETECT_EN
   logic r_ovf, w_eff_a, w_eff_b, w_ovf;
   // a zero magnitude carries no sign for overflow purposes
   assign w_eff_a = r_dp_sign_a && (r_dp_a != '0);
   assign w_eff_b = r_dp_sign_b && (r_dp_b != '0);
   assign w_ovf   = (w_eff_a != w_eff_b) && (r_diff[W-1] != w_eff_a);
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_ovf <= 1'b0;
      else if (r_state == S_CONV)
         r_ovf <= w_ovf;
      else if (r_state == S_DONE && i_ack)
         r_ovf <= 1'b0;
   end
   assign o_ovf = r_ovf;
`else
   assign o_ovf = 1'b0;
`endif
   assign o_busy        = (r_state != S_IDLE);
   assign o_done        = (r_state == S_DONE);
   assign o_dp_rst      = (r_state == S_IDLE) || (r_state == S_DONE);
   assign o_result      = r_result;
   assign o_result_sign = r_result_sign;
   assign o_dp_a        = r_dp_a;
   assign o_dp_b        = r_dp_b;
   assign o_dp_sign_a   = r_dp_sign_a;
   assign o_dp_sign_b   = r_dp_sign_b;
endmodule
